// File: rtl/halt_step_ctrl_pkg.sv
// ============================================================================
// Module : halt_step_ctrl_pkg
// Brief  : Shared state encoding and default constants for halt_step_ctrl.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package halt_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam int C_DEB_LIMIT = 10;
  localparam int C_STEP_LEN  = 1;

endpackage

`default_nettype wire

// File: rtl/halt_step_ctrl_btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : One button channel: 2-FF synchroniser, debounce counter, clean
//          level and registered rising-edge pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
  import halt_step_ctrl_pkg::*;
#(
  parameter int DEB_W     = 4,
  parameter int DEB_LIMIT = C_DEB_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  output logic             clean,
  output logic             rise,
  output logic [DEB_W-1:0] count
);

  localparam logic [DEB_W-1:0] C_LAST = DEB_W'(DEB_LIMIT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_clean;
  logic             r_rise;
  logic [DEB_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        // Flip coincides with the pulse so rise marks the first clean-high cycle
        r_clean <= ~r_clean;
        r_rise  <= ~r_clean;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end
  end

  assign clean = r_clean;
  assign rise  = r_rise;
  assign count = r_cnt;

endmodule

`default_nettype wire

// File: rtl/halt_step_ctrl.sv
// ============================================================================
// Module : halt_step_ctrl
// Brief  : Run/halt/single-step clock-enable controller with debounced buttons.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module halt_step_ctrl
  import halt_step_ctrl_pkg::*;
#(
  parameter int NUM_BTN   = 2,
  parameter int DEB_W     = 4,
  parameter int DEB_LIMIT = C_DEB_LIMIT,
  parameter int STEP_W    = 4,
  parameter int STEP_LEN  = C_STEP_LEN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               clk_dis,
  output logic               clk_en,
  output logic               halted,
  output logic               step_busy,
  output logic [NUM_BTN-1:0] clean_btn,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [DEB_W-1:0]   delay_reg
);

  localparam logic [STEP_W-1:0] C_STEP_LOAD = STEP_W'(STEP_LEN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [STEP_W-1:0] r_step_cnt;
  logic [STEP_W-1:0] w_step_nxt;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    if (gi == 0) begin : g_dbg
      btn_debounce #(
        .DEB_W     (DEB_W),
        .DEB_LIMIT (DEB_LIMIT)
      ) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn[gi]),
        .clean (clean_btn[gi]),
        .rise  (btn_rise[gi]),
        .count (delay_reg)
      );
    end else begin : g_plain
      logic [DEB_W-1:0] w_count_unused;
      btn_debounce #(
        .DEB_W     (DEB_W),
        .DEB_LIMIT (DEB_LIMIT)
      ) u_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn[gi]),
        .clean (clean_btn[gi]),
        .rise  (btn_rise[gi]),
        .count (w_count_unused)
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_step_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_step_cnt <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step_cnt;
    case (r_state)
      ST_RUN: begin
        if (clk_dis || btn_rise[0]) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        // Toggle wins over step when both buttons rise together
        if (!clk_dis && btn_rise[0]) begin
          w_state_nxt = ST_RUN;
        end else if (!clk_dis && btn_rise[1]) begin
          w_state_nxt = ST_STEP;
          w_step_nxt  = C_STEP_LOAD;
        end
      end
      ST_STEP: begin
        if (clk_dis || r_step_cnt == '0) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_step_nxt = r_step_cnt - STEP_W'(1);
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign clk_en    = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign halted    = (r_state == ST_HALT);
  assign step_busy = (r_state == ST_STEP);

endmodule

`default_nettype wire

// File: tb/tb_halt_step_ctrl.sv
// ============================================================================
// Module : tb_halt_step_ctrl
// Brief  : Self-checking bench for halt_step_ctrl (behavioural model + directed).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_halt_step_ctrl;

  localparam int NB        = 3;
  localparam int DW        = 4;
  localparam int DEB_LIMIT = 10;
  localparam int STEP_LEN  = 3;

  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_STEP = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn;
  logic          clk_dis;
  logic          clk_en;
  logic          halted;
  logic          step_busy;
  logic [NB-1:0] clean_btn;
  logic [NB-1:0] btn_rise;
  logic [DW-1:0] delay_reg;

  int checks = 0;
  int errors = 0;

  halt_step_ctrl #(
    .NUM_BTN   (NB),
    .DEB_W     (DW),
    .DEB_LIMIT (DEB_LIMIT),
    .STEP_W    (4),
    .STEP_LEN  (STEP_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .clk_dis   (clk_dis),
    .clk_en    (clk_en),
    .halted    (halted),
    .step_busy (step_busy),
    .clean_btn (clean_btn),
    .btn_rise  (btn_rise),
    .delay_reg (delay_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-channel sync pipe + disagreement run length; FSM as mode + cycles left
  int m_s1[NB], m_s2[NB], m_clean[NB], m_run[NB], m_rise[NB];
  int m_mode, m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_clean[i] = 0; m_run[i] = 0; m_rise[i] = 0;
      end
      m_mode = M_RUN;
      m_left = 0;
    end else begin
      case (m_mode)
        M_RUN:  if (clk_dis || m_rise[0] != 0) m_mode = M_HALT;
        M_HALT: begin
          if (!clk_dis && m_rise[0] != 0) m_mode = M_RUN;
          else if (!clk_dis && m_rise[1] != 0) begin
            m_mode = M_STEP;
            m_left = STEP_LEN;
          end
        end
        default: begin
          m_left = m_left - 1;
          if (clk_dis || m_left == 0) m_mode = M_HALT;
        end
      endcase
      for (int i = 0; i < NB; i++) begin
        m_rise[i] = 0;
        if (m_s2[i] != m_clean[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB_LIMIT) begin
            m_clean[i] = 1 - m_clean[i];
            m_run[i]   = 0;
            m_rise[i]  = m_clean[i];
          end
        end else begin
          m_run[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = int'(btn[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int cb, rb;
      cb = 0; rb = 0;
      for (int i = 0; i < NB; i++) begin
        cb = cb | (m_clean[i] << i);
        rb = rb | (m_rise[i] << i);
      end
      chk("m_clk_en",    int'(clk_en),    int'(m_mode != M_HALT));
      chk("m_halted",    int'(halted),    int'(m_mode == M_HALT));
      chk("m_step_busy", int'(step_busy), int'(m_mode == M_STEP));
      chk("m_clean_btn", int'(clean_btn), cb);
      chk("m_btn_rise",  int'(btn_rise),  rb);
      chk("m_delay_reg", int'(delay_reg), m_run[0]);
    end
  end

  int r0cnt, busy_cnt, en_cnt, maxd, k;

  task automatic step_cyc();
    @(negedge clk);
    if (btn_rise[0]) r0cnt++;
    if (step_busy) busy_cnt++;
    if (step_busy && clk_en) en_cnt++;
    if (int'(delay_reg) > maxd) maxd = int'(delay_reg);
  endtask

  initial begin
    rst_n = 1'b0; btn = '0; clk_dis = 1'b0;
    r0cnt = 0; busy_cnt = 0; en_cnt = 0; maxd = 0;
    repeat (3) step_cyc();
    rst_n = 1'b1;
    step_cyc();
    chk("rst_clk_en", int'(clk_en), 1);
    chk("rst_halted", int'(halted), 0);
    chk("rst_busy",   int'(step_busy), 0);
    chk("rst_clean",  int'(clean_btn), 0);
    chk("rst_delay",  int'(delay_reg), 0);

    // Bounce rejection
    r0cnt = 0; maxd = 0;
    for (int p = 0; p < 10; p++) begin
      btn[0] = 1'b1; repeat (2) step_cyc();
      btn[0] = 1'b0; repeat (5) step_cyc();
    end
    repeat (20) step_cyc();
    chk("bounce_clean", int'(clean_btn[0]), 0);
    chk("bounce_rise",  r0cnt, 0);
    chk("bounce_state", int'(halted), 0);
    chk("bounce_maxd_le9", int'(maxd <= 9), 1);

    // Halt toggle
    r0cnt = 0; k = 0;
    btn[0] = 1'b1;
    while (k < 30 && !clean_btn[0]) begin step_cyc(); k++; end
    chk("toggle_latency", k, 12);
    chk("toggle_rise", int'(btn_rise[0]), 1);
    step_cyc();
    chk("toggle_halted", int'(halted), 1);
    chk("toggle_clk_en", int'(clk_en), 0);
    chk("toggle_rise_once", int'(btn_rise[0]), 0);
    repeat (20) step_cyc();
    chk("toggle_rise_cnt", r0cnt, 1);
    btn[0] = 1'b0; repeat (20) step_cyc();
    btn[0] = 1'b1; repeat (20) step_cyc();
    chk("toggle_back_run", int'(halted), 0);
    chk("toggle_back_en",  int'(clk_en), 1);
    btn[0] = 1'b0; repeat (20) step_cyc();

    // External halt
    clk_dis = 1'b1; step_cyc();
    clk_dis = 1'b0;
    chk("ext_halt", int'(halted), 1);
    repeat (5) step_cyc();
    chk("ext_halt_stays", int'(halted), 1);
    clk_dis = 1'b1; btn[0] = 1'b1; repeat (20) step_cyc();
    chk("ext_hold_btn", int'(halted), 1);
    btn[0] = 1'b0; repeat (20) step_cyc();
    clk_dis = 1'b0; step_cyc();
    chk("ext_still_halt", int'(halted), 1);

    // Single step; btn0 rise lands inside STEP and must be ignored
    busy_cnt = 0; en_cnt = 0;
    btn[1] = 1'b1; step_cyc();
    btn[0] = 1'b1; repeat (25) step_cyc();
    chk("step_busy_len", busy_cnt, 3);
    chk("step_en_len",   en_cnt, 3);
    chk("step_end_halt", int'(halted), 1);
    btn = '0; repeat (20) step_cyc();
    chk("step_rel_halt", int'(halted), 1);

    // Priority: both buttons rise together in HALT
    busy_cnt = 0;
    btn[1:0] = 2'b11; repeat (20) step_cyc();
    chk("prio_run", int'(halted), 0);
    chk("prio_no_step", busy_cnt, 0);
    btn = '0; repeat (20) step_cyc();
    clk_dis = 1'b1; step_cyc(); clk_dis = 1'b0; step_cyc();

    // Abort in cycle 2 of STEP
    busy_cnt = 0; k = 0;
    btn[1] = 1'b1;
    while (k < 30 && !step_busy) begin step_cyc(); k++; end
    chk("abort_step_seen", int'(step_busy), 1);
    step_cyc();
    clk_dis = 1'b1; step_cyc();
    chk("abort_halted", int'(halted), 1);
    chk("abort_busy",   int'(step_busy), 0);
    chk("abort_cycles", busy_cnt, 2);
    clk_dis = 1'b0;
    btn = '0; repeat (20) step_cyc();

    // Reset mid-STEP
    k = 0;
    btn[1] = 1'b1;
    while (k < 30 && !step_busy) begin step_cyc(); k++; end
    chk("rstmid_step_seen", int'(step_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_clk_en", int'(clk_en), 1);
    chk("rstmid_halted", int'(halted), 0);
    chk("rstmid_busy",   int'(step_busy), 0);
    chk("rstmid_clean",  int'(clean_btn), 0);
    chk("rstmid_delay",  int'(delay_reg), 0);
    step_cyc();
    #2 rst_n = 1'b1;
    repeat (20) step_cyc();
    chk("rstmid_run", int'(halted), 0);
    chk("rstmid_en",  int'(clk_en), 1);

    // Pass-through channel
    btn[2] = 1'b1; repeat (15) step_cyc();
    chk("ch2_clean", int'(clean_btn[2]), 1);
    chk("ch2_no_fsm", int'(halted), 0);
    btn = '0; repeat (3) step_cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/halt_step_ctrl.md
Name: halt_step_ctrl

Overview:
Parametrised run/halt/single-step clock-enable controller for the lab CPU datapath.
- Debounces NUM_BTN push-buttons. Button 0 toggles halt; button 1 requests a single step of STEP_LEN cycles. Higher buttons are debounced and passed through only.
- Also accepts an external halt request.
- Drives a clock-enable (not a gated clock) to downstream logic and exposes debounce state for debug.

Parameters:
- NUM_BTN, 2, number of button channels; must be >= 2.
- DEB_W, 4, width of each per-channel debounce counter.
- DEB_LIMIT, 10, consecutive stable cycles needed to accept a change; 1 <= DEB_LIMIT < 2^DEB_W.
- STEP_W, 4, width of the step-length counter.
- STEP_LEN, 1, clk_en-high cycles per step; 1 <= STEP_LEN < 2^STEP_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn  in  NUM_BTN  raw asynchronous button levels.
- clk_dis  in  1  synchronous halt request; level-sensitive.
- clk_en  out  1  enable for the downstream datapath.
- halted  out  1  high when in HALT.
- step_busy  out  1  high when in STEP.
- clean_btn  out  NUM_BTN  debounced button levels.
- btn_rise  out  NUM_BTN  one-cycle pulse on a clean_btn 0->1 transition.
- delay_reg  out  DEB_W  debounce counter of channel 0, for debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=RUN, so clk_en=1, halted=0, step_busy=0.
  - Synchronisers, clean_btn, btn_rise, all debounce counters and the step counter clear to 0.
- Synchronise: each btn bit passes through a 2-FF synchroniser; sync_i is the second stage.
- Debounce, per channel:
  - If sync_i == clean_i: counter clears.
  - Else if counter == DEB_LIMIT-1: clean_i flips and counter clears.
  - Else: counter increments.
  - Any bounce back to the clean level restarts the count.
  - Raw edge to clean_btn change: 2+DEB_LIMIT cycles.
  - Counter never exceeds DEB_LIMIT-1, so it never wraps.
- btn_rise_i: registered; high exactly in the first cycle clean_i reads 1; never high two consecutive cycles.
- FSM states: RUN, HALT, STEP. Outputs are Moore-decoded from the state register:
  - clk_en = RUN|STEP; halted = HALT; step_busy = STEP.
- Transitions (take effect at the next edge after the condition):
  - RUN -> HALT: clk_dis=1 or btn_rise[0]=1.
  - HALT -> RUN: btn_rise[0]=1 and clk_dis=0. With clk_dis=1, stay in HALT.
  - HALT -> STEP: btn_rise[1]=1, btn_rise[0]=0 and clk_dis=0. Load step counter with STEP_LEN-1.
  - STEP: if counter==0, go to HALT; otherwise decrement. clk_en is therefore high for exactly STEP_LEN cycles.
  - STEP -> HALT immediately on clk_dis=1 (abort).
  - In STEP, btn_rise[0] and btn_rise[1] are ignored; step requests are not queued.
- Simultaneous events:
  - In HALT, btn_rise[0] has priority over btn_rise[1], giving HALT -> RUN.
  - In RUN, clk_dis and btn_rise[0] together give a single transition to HALT (no double toggle).
- Reset mid-operation (any state, including STEP with a partial count) returns to RUN with all counters cleared.
- Channels 2..NUM_BTN-1 do not affect the FSM.

Decomposition:
- Shared package:
  - state encoding constants ST_RUN=2'd0, ST_HALT=2'd1, ST_STEP=2'd2.
  - default DEB_LIMIT and STEP_LEN constants.
- Sub-module btn_debounce (parameters DEB_W, DEB_LIMIT): one channel containing synchroniser, counter, clean level and rise pulse.
  - Instantiated NUM_BTN times by a generate loop.
  - Channel 0 counter exported as delay_reg.
- FSM and step counter live in halt_step_ctrl.

Test Plan:
- Bounce rejection (DEB_LIMIT=10): 10 pulses of btn[0] at 1 for 2 cycles then 0 for 5 cycles, followed by btn[0] held at 0 -> clean_btn[0] stays 0, btn_rise=0, state stays RUN, delay_reg never exceeds 9.
- Halt toggle: btn[0] held at 1 -> clean_btn[0]=1 exactly 12 cycles after the edge, one btn_rise[0] pulse, halted=1 and clk_en=0 on the next cycle. Release, then press again -> back to RUN with clk_en=1.
- External halt: in RUN, 1-cycle clk_dis pulse -> halted=1 the next cycle and stays 1 after clk_dis drops. btn[0] press while clk_dis is held high -> remains in HALT.
- Single step (STEP_LEN=3): in HALT, press btn[1] -> step_busy=1 and clk_en=1 for exactly 3 cycles, then halted=1. A second btn[1] rise during STEP produces no extra cycles.
- Priority: in HALT, btn_rise[0] and btn_rise[1] in the same cycle -> RUN, never STEP. clk_dis=1 in cycle 2 of a 3-cycle STEP -> HALT the next cycle.
- Reset mid-STEP: drop rst_n asynchronously between clock edges -> clk_en=1, halted=0, step_busy=0, clean_btn=0, delay_reg=0 immediately. After release, state is RUN.
